can_bit_destuffer: RTL

Parametrised successor of the bit-stuff error block for the CAN receive path. Sits between the bit-sampling stage and the frame decoder. Checks dynamic stuffing (classic CAN and FD arbitration/data) and fixed stuffing (CAN FD CRC field). Removes stuff bits, counts dynamic stuff bits for the FD stuff-count check, and flags violations with a sticky error.

---
 rtl/can_bit_destuffer_if.sv | 24 ++
 rtl/can_bit_destuffer.sv | 110 +++++++++++
 2 files changed

// File: rtl/can_bit_destuffer_if.sv
// Bit-level bus between the sample-point stage, the destuffer and the frame decoder.
interface can_bit_destuffer_if #(
    parameter int unsigned CNT_W = 3
);
    logic             RX;
    logic             F_STF;
    logic             F_FIX;
    logic             CLR;
    logic             BIT_OUT;
    logic             BIT_VLD;
    logic             STF_BIT;
    logic             STF_ERR;
    logic [CNT_W-1:0] STF_CNT;

    modport master (
        output RX, F_STF, F_FIX, CLR,
        input  BIT_OUT, BIT_VLD, STF_BIT, STF_ERR, STF_CNT
    );

    modport slave (
        input  RX, F_STF, F_FIX, CLR,
        output BIT_OUT, BIT_VLD, STF_BIT, STF_ERR, STF_CNT
    );
endinterface

// File: rtl/can_bit_destuffer.sv
// CAN receive-path stuff-bit remover and checker for dynamic (classic/FD) and fixed (FD CRC) stuffing.
// Outputs after a sample-point edge describe the RX bit sampled at that edge.
module can_bit_destuffer #(
    parameter int unsigned STUFF_LEN = 5,
    parameter int unsigned FIXED_LEN = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                SP,
    input  logic                reset,
    can_bit_destuffer_if.slave  bus
);
    localparam int unsigned RUN_W  = $clog2(STUFF_LEN + 1);
    localparam int unsigned FPOS_W = $clog2(FIXED_LEN + 1);

    logic              last_q,    last_d;
    logic [RUN_W-1:0]  run_q,     run_d;
    logic [FPOS_W-1:0] fpos_q,    fpos_d;
    logic              fix_q,     fix_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_vld_q, bit_vld_d;
    logic              stf_bit_q, stf_bit_d;
    logic              stf_err_q, stf_err_d;
    logic [CNT_W-1:0]  stf_cnt_q, stf_cnt_d;
    logic              err_set;
    logic [FPOS_W-1:0] fpos_eff;

    // Next-state and output decode for the three stuffing modes.
    always_comb begin
        last_d    = bus.RX;
        bit_out_d = bus.RX;
        fix_d     = bus.F_FIX;
        bit_vld_d = 1'b1;
        stf_bit_d = 1'b0;
        run_d     = run_q;
        fpos_d    = fpos_q;
        stf_cnt_d = stf_cnt_q;
        err_set   = 1'b0;
        fpos_eff  = fix_q ? fpos_q : FPOS_W'(0);

        if (bus.F_FIX) begin
            run_d = RUN_W'(0);
            if (fpos_eff == FPOS_W'(0)) begin
                if (bus.RX != last_q) begin
                    stf_bit_d = 1'b1;
                    bit_vld_d = 1'b0;
                end else begin
                    err_set = 1'b1;
                end
                fpos_d = FPOS_W'(1);
            end else begin
                fpos_d = (fpos_eff == FPOS_W'(FIXED_LEN)) ? FPOS_W'(0) : fpos_eff + FPOS_W'(1);
            end
        end else if (bus.F_STF) begin
            if (run_q == RUN_W'(STUFF_LEN)) begin
                if (bus.RX != last_q) begin
                    stf_bit_d = 1'b1;
                    bit_vld_d = 1'b0;
                    stf_cnt_d = stf_cnt_q + CNT_W'(1);
                end else begin
                    err_set = 1'b1;
                end
                run_d = RUN_W'(1);
            end else begin
                run_d = (run_q != RUN_W'(0) && bus.RX == last_q) ? run_q + RUN_W'(1) : RUN_W'(1);
            end
        end else begin
            run_d  = RUN_W'(0);
            fpos_d = FPOS_W'(0);
        end

        // A violation on this edge wins over a simultaneous clear.
        if (err_set) begin
            stf_err_d = 1'b1;
        end else if (bus.CLR) begin
            stf_err_d = 1'b0;
        end else begin
            stf_err_d = stf_err_q;
        end
    end

    always_ff @(posedge SP) begin
        if (!reset) begin
            last_q    <= 1'b1;
            run_q     <= RUN_W'(0);
            fpos_q    <= FPOS_W'(0);
            fix_q     <= 1'b0;
            bit_out_q <= 1'b1;
            bit_vld_q <= 1'b0;
            stf_bit_q <= 1'b0;
            stf_err_q <= 1'b0;
            stf_cnt_q <= CNT_W'(0);
        end else begin
            last_q    <= last_d;
            run_q     <= run_d;
            fpos_q    <= fpos_d;
            fix_q     <= fix_d;
            bit_out_q <= bit_out_d;
            bit_vld_q <= bit_vld_d;
            stf_bit_q <= stf_bit_d;
            stf_err_q <= stf_err_d;
            stf_cnt_q <= stf_cnt_d;
        end
    end

    assign bus.BIT_OUT = bit_out_q;
    assign bus.BIT_VLD = bit_vld_q;
    assign bus.STF_BIT = stf_bit_q;
    assign bus.STF_ERR = stf_err_q;
    assign bus.STF_CNT = stf_cnt_q;
endmodule
